// File: rtl/sa_ax_channel_pkg.sv
// sa_ax_channel_pkg: shared interconnect widths and reset constants for Ax channel logic
package sa_ax_channel_pkg;
  localparam int BURST_W = 2;
  localparam int LEN_W   = 3;
  localparam int SIZE_W  = 3;
  localparam logic [BURST_W-1:0] RST_BURST = '0;
  localparam logic [LEN_W-1:0]   RST_LEN   = '0;
  localparam logic [SIZE_W-1:0]  RST_SIZE  = '0;
endpackage

// File: rtl/fifo.sv
// fifo: synchronous first-word-fall-through FIFO with occupancy count
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout  = mem[rp];
  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) mem[wp] <= din;
      if (wr) wp <= wp == AW'(DEPTH-1) ? '0 : wp + AW'(1);
      if (rd) rp <= rp == AW'(DEPTH-1) ? '0 : rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/sa_rr_arbiter.sv
// sa_rr_arbiter: one-hot request picker searching upward from ptr (ptr=0 gives fixed priority)
module sa_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
  end
  assign gnt = |req ? N'(1) << idx : '0;
endmodule

// File: rtl/sa_ax_channel.sv
// sa_ax_channel: arbitrates master Ax requests onto one slave and tracks data-burst ownership.
// Define SA_AX_RR_ARB_EN for round-robin arbitration; otherwise lowest index wins.
module sa_ax_channel
  import sa_ax_channel_pkg::*;
#(
  parameter int MST_AMT         = 2,
  parameter int OUTSTANDING_AMT = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int TRANS_MST_ID_W  = 5,
  localparam int MST_ID_W = MST_AMT > 1 ? $clog2(MST_AMT) : 1
) (
  input  logic                               ACLK_i,
  input  logic                               ARESET_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]  dsp_AxID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]      dsp_AxADDR_i,
  input  logic [BURST_W*MST_AMT-1:0]         dsp_AxBURST_i,
  input  logic [LEN_W*MST_AMT-1:0]           dsp_AxLEN_i,
  input  logic [SIZE_W*MST_AMT-1:0]          dsp_AxSIZE_i,
  input  logic [MST_AMT-1:0]                 dsp_AxVALID_i,
  output logic [MST_AMT-1:0]                 dsp_AxREADY_o,
  output logic [MST_ID_W+TRANS_MST_ID_W-1:0] s_AxID_o,
  output logic [ADDR_WIDTH-1:0]              s_AxADDR_o,
  output logic [BURST_W-1:0]                 s_AxBURST_o,
  output logic [LEN_W-1:0]                   s_AxLEN_o,
  output logic [SIZE_W-1:0]                  s_AxSIZE_o,
  output logic                               s_AxVALID_o,
  input  logic                               s_AxREADY_i,
  input  logic                               s_xVALID_i,
  input  logic                               s_xREADY_i,
  output logic [MST_ID_W-1:0]                xDATA_mst_id_o,
  output logic                               xDATA_disable_o
);
  logic [MST_AMT-1:0] gnt;
  logic [MST_ID_W-1:0] idx, ptr;
  logic [MST_ID_W+LEN_W-1:0] head;
  logic [LEN_W-1:0] cnt;
  logic fifo_full, fifo_empty, load_ok, push, beat, pop;
  assign load_ok = (!s_AxVALID_o || s_AxREADY_i) && !fifo_full;
  assign push = load_ok && |dsp_AxVALID_i;
  assign dsp_AxREADY_o = push ? gnt : '0;
  assign beat = s_xVALID_i && s_xREADY_i && !fifo_empty;
  assign pop = beat && cnt == head[LEN_W-1:0];
  assign xDATA_disable_o = fifo_empty;
  assign xDATA_mst_id_o = fifo_empty ? '0 : head[MST_ID_W+LEN_W-1:LEN_W];
  sa_rr_arbiter #(.N(MST_AMT), .IW(MST_ID_W)) u_arb (
    .req(dsp_AxVALID_i), .ptr(ptr), .gnt(gnt), .idx(idx)
  );
  fifo #(.WIDTH(MST_ID_W+LEN_W), .DEPTH(OUTSTANDING_AMT)) u_order (
    .clk(ACLK_i), .rst(ARESET_i), .wr_en(push), .din({idx, dsp_AxLEN_i[idx*LEN_W +: LEN_W]}),
    .rd_en(pop), .dout(head), .full(fifo_full), .empty(fifo_empty)
  );
`ifdef SA_AX_RR_ARB_EN
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) ptr <= '0;
    else if (push) ptr <= idx == MST_ID_W'(MST_AMT-1) ? '0 : idx + MST_ID_W'(1);
  end
`else
  assign ptr = '0;
`endif
  // Payload only reloads when the stage is free, so it stays stable while stalled
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      s_AxVALID_o <= 1'b0;
      s_AxID_o    <= '0;
      s_AxADDR_o  <= '0;
      s_AxBURST_o <= RST_BURST;
      s_AxLEN_o   <= RST_LEN;
      s_AxSIZE_o  <= RST_SIZE;
      cnt         <= '0;
    end else begin
      if (push) begin
        s_AxVALID_o <= 1'b1;
        s_AxID_o    <= {idx, dsp_AxID_i[idx*TRANS_MST_ID_W +: TRANS_MST_ID_W]};
        s_AxADDR_o  <= dsp_AxADDR_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
        s_AxBURST_o <= dsp_AxBURST_i[idx*BURST_W +: BURST_W];
        s_AxLEN_o   <= dsp_AxLEN_i[idx*LEN_W +: LEN_W];
        s_AxSIZE_o  <= dsp_AxSIZE_i[idx*SIZE_W +: SIZE_W];
      end else if (s_AxREADY_i) s_AxVALID_o <= 1'b0;
      if (beat) cnt <= pop ? '0 : cnt + LEN_W'(1);
    end
  end
endmodule

// File: tb/tb_sa_ax_channel.sv
// tb_sa_ax_channel: directed self-checking bench for sa_ax_channel (honours SA_AX_RR_ARB_EN)
module tb_sa_ax_channel;
  logic clk = 1'b0;
  logic rst;
  logic [9:0]  dsp_id;
  logic [63:0] dsp_addr;
  logic [3:0]  dsp_burst;
  logic [5:0]  dsp_len, dsp_size;
  logic [1:0]  dsp_valid, dsp_ready;
  logic [5:0]  s_id;
  logic [31:0] s_addr;
  logic [1:0]  s_burst;
  logic [2:0]  s_len, s_size;
  logic s_valid, s_ready, x_valid, x_ready, x_mst, x_dis;
  int checks = 0;
  int failures = 0;
`ifdef SA_AX_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  always #5 clk = ~clk;
  sa_ax_channel dut (
    .ACLK_i(clk), .ARESET_i(rst),
    .dsp_AxID_i(dsp_id), .dsp_AxADDR_i(dsp_addr), .dsp_AxBURST_i(dsp_burst),
    .dsp_AxLEN_i(dsp_len), .dsp_AxSIZE_i(dsp_size), .dsp_AxVALID_i(dsp_valid),
    .dsp_AxREADY_o(dsp_ready),
    .s_AxID_o(s_id), .s_AxADDR_o(s_addr), .s_AxBURST_o(s_burst), .s_AxLEN_o(s_len),
    .s_AxSIZE_o(s_size), .s_AxVALID_o(s_valid), .s_AxREADY_i(s_ready),
    .s_xVALID_i(x_valid), .s_xREADY_i(x_ready),
    .xDATA_mst_id_o(x_mst), .xDATA_disable_o(x_dis)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    dsp_id = '0; dsp_addr = '0; dsp_burst = '0; dsp_len = '0; dsp_size = '0; dsp_valid = '0;
    s_ready = 1'b0; x_valid = 1'b0; x_ready = 1'b1;
    cyc(); cyc();
    chk("rst_valid", s_valid, 0);
    chk("rst_ready", dsp_ready, 0);
    chk("rst_disable", x_dis, 1);
    chk("rst_mst", x_mst, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_id", s_id, 0);
    rst = 1'b0;
    // single master 0, LEN=3
    dsp_id = {5'h0A, 5'h15}; dsp_addr = {32'h2000, 32'h1000};
    dsp_burst = {2'd1, 2'd1}; dsp_len = {3'd0, 3'd3}; dsp_size = {3'd2, 3'd2};
    dsp_valid = 2'b01; s_ready = 1'b1;
    #1 chk("a_ready_c0", dsp_ready, 2'b01);
    cyc();
    dsp_valid = 2'b00;
    #1 chk("a_valid_c1", s_valid, 1);
    chk("a_id", s_id, 6'h15);
    chk("a_addr", s_addr, 32'h1000);
    chk("a_len", s_len, 3);
    chk("a_burst", s_burst, 1);
    chk("a_size", s_size, 2);
    chk("a_disable_busy", x_dis, 0);
    cyc();
    chk("a_valid_drop", s_valid, 0);
    x_valid = 1'b1;
    cyc(); cyc(); cyc();
    chk("a_disable_3beats", x_dis, 0);
    cyc();
    x_valid = 1'b0;
    chk("a_disable_4beats", x_dis, 1);
    // both masters valid; LEN=0 entries fill the order FIFO
    dsp_len = {3'd0, 3'd0}; dsp_valid = 2'b11;
    #1 chk("b_gnt0", dsp_ready, 2'b01);
    cyc();
    #1 chk("b_gnt1", dsp_ready, RR ? 2'b10 : 2'b01);
    chk("b_id0", s_id, 6'h15);
    cyc();
    #1 chk("b_gnt2", dsp_ready, 2'b01);
    chk("b_id1", s_id, RR ? 6'h2A : 6'h15);
    cyc();
    #1 chk("b_gnt3", dsp_ready, RR ? 2'b10 : 2'b01);
    cyc();
    dsp_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1 chk("b_gnt_m1", dsp_ready, 2'b10);
      cyc();
    end
    #1 chk("b_full_ready", dsp_ready, 0);
    chk("b_head_mst", x_mst, 0);
    x_valid = 1'b1;
    #1 chk("b_pop_same_cycle", dsp_ready, 0);
    cyc();
    x_valid = 1'b0;
    #1 chk("b_resume", dsp_ready, 2'b10);
    chk("b_head2_mst", x_mst, RR ? 1 : 0);
    cyc();
    dsp_valid = 2'b00;
    x_valid = 1'b1;
    repeat (8) cyc();
    x_valid = 1'b0;
    chk("b_drained", x_dis, 1);
    // slave stall holds the stage and blocks grants
    dsp_id[4:0] = 5'h03; dsp_addr[31:0] = 32'h3000; dsp_len[2:0] = 3'd1;
    s_ready = 1'b0; dsp_valid = 2'b01;
    #1 chk("c_gnt", dsp_ready, 2'b01);
    cyc();
    dsp_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1 chk("c_hold_ready", dsp_ready, 0);
      chk("c_hold_valid", s_valid, 1);
      chk("c_hold_addr", s_addr, 32'h3000);
      chk("c_hold_id", s_id, 6'h03);
      cyc();
    end
    dsp_valid = 2'b00; s_ready = 1'b1;
    cyc();
    chk("c_released", s_valid, 0);
    // reset mid-burst with a loaded stage
    x_valid = 1'b1;
    cyc();
    x_valid = 1'b0; s_ready = 1'b0; dsp_valid = 2'b10;
    cyc();
    chk("d_loaded", s_valid, 1);
    chk("d_busy", x_dis, 0);
    dsp_valid = 2'b00; rst = 1'b1;
    cyc();
    chk("d_valid", s_valid, 0);
    chk("d_ready", dsp_ready, 0);
    chk("d_disable", x_dis, 1);
    chk("d_mst", x_mst, 0);
    chk("d_addr", s_addr, 0);
    chk("d_id", s_id, 0);
    chk("d_len", s_len, 0);
    rst = 1'b0; s_ready = 1'b1;
    // beats with an empty FIFO are ignored; counter starts clean
    x_valid = 1'b1;
    cyc(); cyc();
    x_valid = 1'b0; dsp_valid = 2'b01;
    cyc();
    dsp_valid = 2'b00; x_valid = 1'b1;
    cyc();
    chk("e_one_beat", x_dis, 0);
    cyc();
    x_valid = 1'b0;
    chk("e_two_beats", x_dis, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sa_ax_channel.md
SA_AX_CHANNEL -- requirements
Module: sa_Ax_channel

Interface
REQ-001 SHALL have parameter MST_AMT, default 2, number of master-side dispatchers feeding this slave.
REQ-002 SHALL have parameter OUTSTANDING_AMT, default 8, order-FIFO depth, which is the maximum number of accepted Ax not yet fully data-transferred.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have parameter TRANS_MST_ID_W, default 5, master transaction ID width; MST_ID_W = clog2(MST_AMT), minimum 1.
REQ-005 SHALL have port ACLK_i, input, 1 bit: the single clock.
REQ-006 SHALL have port ARESET_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port dsp_AxID_i, input, TRANS_MST_ID_W*MST_AMT bits: per-master ID; slice m belongs to master m.
REQ-008 SHALL have port dsp_AxADDR_i, input, ADDR_WIDTH*MST_AMT bits: per-master address.
REQ-009 SHALL have port dsp_AxBURST_i, input, 2*MST_AMT bits: per-master burst type.
REQ-010 SHALL have port dsp_AxLEN_i, input, 3*MST_AMT bits: per-master beats-1.
REQ-011 SHALL have port dsp_AxSIZE_i, input, 3*MST_AMT bits: per-master beat size.
REQ-012 SHALL have port dsp_AxVALID_i, input, MST_AMT bits: per-master request.
REQ-013 SHALL have port dsp_AxREADY_o, output, MST_AMT bits: per-master accept; one-hot or zero.
REQ-014 SHALL have port s_AxID_o, output, MST_ID_W+TRANS_MST_ID_W bits: {winning master index, master ID}.
REQ-015 SHALL have ports s_AxADDR_o / s_AxBURST_o / s_AxLEN_o / s_AxSIZE_o, outputs, ADDR_WIDTH/2/3/3 bits: registered payload to the slave.
REQ-016 SHALL have ports s_AxVALID_o (output, 1) and s_AxREADY_i (input, 1): slave address handshake.
REQ-017 SHALL have ports s_xVALID_i and s_xREADY_i, inputs, 1 bit each: slave-side data-beat handshake observation.
REQ-018 SHALL have port xDATA_mst_id_o, output, MST_ID_W bits: master owning the current data burst.
REQ-019 SHALL have port xDATA_disable_o, output, 1 bit: high when no burst is pending (order FIFO empty).

Function
REQ-020 SHALL hold one output register stage; "load_ok" = (stage empty or s_AxVALID_o&s_AxREADY_i) and order FIFO not full.
REQ-021 SHALL, when load_ok and any dsp_AxVALID_i is high, grant exactly one master, assert its dsp_AxREADY_o in the same cycle, and load its payload so s_AxVALID_o is high the next cycle (latency 1).
REQ-022 SHALL keep s_AxVALID_o and all s_Ax* outputs stable until s_AxREADY_i is sampled high.
REQ-023 SHALL, on grant, push {master index, AxLEN} into the order FIFO in the same cycle.
REQ-024 SHALL count data beats (s_xVALID_i&s_xREADY_i) in a 3-bit counter; on a beat with counter==head AxLEN, it SHALL pop the FIFO and clear the counter, otherwise increment.
REQ-025 SHALL drive xDATA_mst_id_o from the FIFO head index.
REQ-026 SHALL, when the FIFO is full, hold all dsp_AxREADY_o low; a pop in the same cycle does not unblock until the next cycle.
REQ-027 SHALL support simultaneous push and pop, leaving the occupancy unchanged.
REQ-028 SHALL ignore beats while the FIFO is empty, leaving the counter unchanged.

Reset
REQ-029 SHALL, while ARESET_i is high at a clock edge, empty the stage and FIFO and clear the counter and round-robin pointer (pointer = master 0).
REQ-030 SHALL present after reset: s_AxVALID_o=0, dsp_AxREADY_o=0, xDATA_disable_o=1, xDATA_mst_id_o=0, and payload outputs=0; reset mid-burst discards all pending state.

Configuration
REQ-031 SHALL, with SA_AX_RR_ARB_EN defined, use round-robin arbitration: search from the master after the last grant, and update the pointer only on grant.
REQ-032 SHALL, with SA_AX_RR_ARB_EN undefined, use fixed priority (lowest index wins) and contain no pointer register.

Structure
REQ-033 SHALL take the BURST width (2), LEN width (3), SIZE width (3), and reset constants from the shared interconnect package.
REQ-034 SHALL instantiate the existing fifo module for the order FIFO; the arbiter is a natural sub-module, sa_rr_arbiter.

Verification
REQ-035 SHALL cover: single master 0 valid, LEN=3, slave ready -> READY[0] at cycle 0, s_AxVALID at cycle 1, s_AxID={0,ID}, 4 beats then pop and xDATA_disable_o=1.
REQ-036 SHALL cover (RR enabled): both masters continuously valid -> grants alternate 0,1,0,1.
REQ-037 SHALL cover (RR disabled): both masters continuously valid -> master 0 is always granted.
REQ-038 SHALL cover: s_AxREADY_i low for 5 cycles -> outputs stable and no new grants.
REQ-039 SHALL cover: 8 grants with no beats -> FIFO full and READY=0; 1 LEN=0 beat -> grant resumes the following cycle.
REQ-040 SHALL cover: reset asserted mid-burst -> all outputs return to their reset values on the next edge.
